// File: rtl/pong_match_controller.sv
`default_nettype none
// ============================================================================
// Module      : pong_match_controller
// Description : Match sequencer for a two-player pong game. Tracks the match
//               phase (idle, serve, play, point, game over), keeps both
//               players' scores, decides the serve direction and announces
//               the winner. All motion-control outputs are Moore-decoded from
//               the registered state.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MAX_SCORE     points that win a match (1..15)
//   SERVE_FRAMES  frame ticks spent in SERVE before play starts (1..255)
//   POINT_FRAMES  frame ticks spent in POINT before the next serve (1..255)
// Ports
//   clock         in   system clock
//   reset_n       in   asynchronous active-low reset
//   frame_tick    in   one-cycle pulse per game frame
//   start         in   start button level (already synchronised)
//   miss_top      in   pulse: ball passed paddle 2, player 1 scores
//   miss_bottom   in   pulse: ball passed paddle 1, player 2 scores
//   ball_reset    out  hold the ball at centre
//   ball_enable   out  ball motion permitted
//   paddle_enable out  paddle motion permitted
//   serve_dir     out  0 = serve toward player 1, 1 = toward player 2
//   score_1/2     out  player scores (4 bits each)
//   winner        out  00 none, 01 player 1, 10 player 2
//   state         out  current state encoding for the graphics overlay
// ============================================================================
module pong_match_controller #(
  parameter int MAX_SCORE    = 10,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       miss_top,
  input  logic       miss_bottom,
  output logic       ball_reset,
  output logic       ball_enable,
  output logic       paddle_enable,
  output logic       serve_dir,
  output logic [3:0] score_1,
  output logic [3:0] score_2,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam logic [3:0] SCORE_LIMIT = 4'(MAX_SCORE);
  localparam logic [7:0] SERVE_LAST  = 8'(SERVE_FRAMES);
  localparam logic [7:0] POINT_LAST  = 8'(POINT_FRAMES);

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t     state_q,     state_d;
  logic [3:0] score_1_q,   score_1_d;
  logic [3:0] score_2_q,   score_2_d;
  logic [1:0] winner_q,    winner_d;
  logic       serve_dir_q, serve_dir_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       start_q,     start_d;
  // armed_q is low only during the first clock after reset release. It stops
  // a start button that was held through reset from looking like a fresh
  // press, since start_q itself comes out of reset at 0.
  logic       armed_q,     armed_d;

  logic       start_edge;
  logic [7:0] frame_cnt_inc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      score_1_q   <= 4'd0;
      score_2_q   <= 4'd0;
      winner_q    <= WIN_NONE;
      serve_dir_q <= 1'b0;
      frame_cnt_q <= 8'd0;
      start_q     <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_1_q   <= score_1_d;
      score_2_q   <= score_2_d;
      winner_q    <= winner_d;
      serve_dir_q <= serve_dir_d;
      frame_cnt_q <= frame_cnt_d;
      start_q     <= start_d;
      armed_q     <= armed_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    start_d       = start;
    armed_d       = 1'b1;
    start_edge    = start & ~start_q & armed_q;
    frame_cnt_inc = frame_cnt_q + 8'd1;

    state_d       = state_q;
    score_1_d     = score_1_q;
    score_2_d     = score_2_q;
    winner_d      = winner_q;
    serve_dir_d   = serve_dir_q;
    frame_cnt_d   = frame_cnt_q;

    case (state_q)
      // IDLE and OVER share the same "new match" entry. A frame_tick that
      // coincides with the start edge is deliberately not counted: the
      // counter is cleared here and counting begins once SERVE is reached.
      ST_IDLE, ST_OVER: begin
        if (start_edge) begin
          state_d     = ST_SERVE;
          score_1_d   = 4'd0;
          score_2_d   = 4'd0;
          winner_d    = WIN_NONE;
          serve_dir_d = 1'b0;
          frame_cnt_d = 8'd0;
        end
      end

      ST_SERVE: begin
        if (frame_tick) begin
          if (frame_cnt_inc == SERVE_LAST) begin
            state_d     = ST_PLAY;
            frame_cnt_d = 8'd0;
          end else begin
            frame_cnt_d = frame_cnt_inc;
          end
        end
      end

      ST_PLAY: begin
        if (miss_top && miss_bottom) begin
          // Simultaneous misses: replay the point with no score change.
          state_d     = ST_POINT;
          frame_cnt_d = 8'd0;
        end else if (miss_top) begin
          if (score_1_q != SCORE_LIMIT) begin
            score_1_d = score_1_q + 4'd1;
          end
          serve_dir_d = 1'b1;
          state_d     = ST_POINT;
          frame_cnt_d = 8'd0;
        end else if (miss_bottom) begin
          if (score_2_q != SCORE_LIMIT) begin
            score_2_d = score_2_q + 4'd1;
          end
          serve_dir_d = 1'b0;
          state_d     = ST_POINT;
          frame_cnt_d = 8'd0;
        end
      end

      // Scores are frozen in POINT, so the win test made on the first cycle
      // gives the same answer on every cycle; the winning point leaves on
      // the very next edge.
      ST_POINT: begin
        if (score_1_q == SCORE_LIMIT) begin
          state_d  = ST_OVER;
          winner_d = WIN_P1;
        end else if (score_2_q == SCORE_LIMIT) begin
          state_d  = ST_OVER;
          winner_d = WIN_P2;
        end else if (frame_tick) begin
          if (frame_cnt_inc == POINT_LAST) begin
            state_d     = ST_SERVE;
            frame_cnt_d = 8'd0;
          end else begin
            frame_cnt_d = frame_cnt_inc;
          end
        end
      end

      // Unused encodings recover to IDLE on the next clock.
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Moore outputs, decoded from the registered state only
  // --------------------------------------------------------------------------
  always_comb begin
    ball_reset    = (state_q != ST_PLAY);
    ball_enable   = (state_q == ST_PLAY);
    paddle_enable = (state_q == ST_SERVE) || (state_q == ST_PLAY);
  end

  assign serve_dir = serve_dir_q;
  assign score_1   = score_1_q;
  assign score_2   = score_2_q;
  assign winner    = winner_q;
  assign state     = state_q;

endmodule
`default_nettype wire

// File: doc/pong_match_controller.md
PONG_MATCH_CONTROLLER -- requirements
Module: pong_match_controller

Interface
REQ-001 SHALL have parameter MAX_SCORE, default 10, points that win a match (1..15).
REQ-002 SHALL have parameter SERVE_FRAMES, default 60, frame ticks in SERVE before play starts (1..255).
REQ-003 SHALL have parameter POINT_FRAMES, default 30, frame ticks in POINT before the next serve (1..255).
REQ-004 SHALL have port clock  in  1  system clock (50 MHz).
REQ-005 SHALL have port reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port frame_tick  in  1  one-cycle pulse per game frame (30 Hz), synchronous to clock.
REQ-007 SHALL have port start  in  1  start button level, active-high, already synchronised.
REQ-008 SHALL have port miss_top  in  1  one-cycle pulse: ball passed paddle 2, so player 1 scores.
REQ-009 SHALL have port miss_bottom  in  1  one-cycle pulse: ball passed paddle 1, so player 2 scores.
REQ-010 SHALL have port ball_reset  out  1  holds ball at centre.
REQ-011 SHALL have port ball_enable  out  1  ball motion permitted.
REQ-012 SHALL have port paddle_enable  out  1  paddle motion permitted.
REQ-013 SHALL have port serve_dir  out  1  0 = serve toward player 1, 1 = toward player 2.
REQ-014 SHALL have ports score_1, score_2  out  4 each  player scores.
REQ-015 SHALL have port winner  out  2  00 none, 01 player 1, 10 player 2.
REQ-016 SHALL have port state  out  3  current state encoding for graphics overlay.

Function
REQ-017 SHALL implement states IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4; encodings 5-7 SHALL return to IDLE on the next clock.
REQ-018 SHALL detect start rising edge as start & ~start_q, start_q registered; a start held through reset release SHALL NOT count as an edge.
REQ-019 IDLE: on start edge -> SERVE; score_1, score_2, winner cleared to 0; serve_dir set to 0.
REQ-020 SERVE: 8-bit frame counter cleared on entry, incremented per frame_tick; on the tick bringing it to SERVE_FRAMES -> PLAY.
REQ-021 PLAY: miss_top alone -> score_1+1, serve_dir=1, -> POINT; miss_bottom alone -> score_2+1, serve_dir=0, -> POINT.
REQ-022 PLAY: miss_top and miss_bottom in the same cycle -> no score change, serve_dir unchanged, -> POINT (replayed point).
REQ-023 miss_top/miss_bottom outside PLAY SHALL be ignored.
REQ-024 POINT: if score_1==MAX_SCORE -> OVER with winner=01; else if score_2==MAX_SCORE -> OVER with winner=10; checked on the first cycle in POINT, transition next edge.
REQ-025 POINT without winner: frame counter cleared on entry; after POINT_FRAMES frame_ticks -> SERVE.
REQ-026 OVER: scores and winner held; start edge -> SERVE with scores, winner and serve_dir cleared, identical to REQ-019.
REQ-027 Scores SHALL never exceed MAX_SCORE; no wrap.
REQ-028 Outputs SHALL be decoded from the registered state only (Moore): ball_reset=1 in IDLE, SERVE, POINT, OVER; ball_enable=1 only in PLAY; paddle_enable=1 in SERVE and PLAY.
REQ-029 State change SHALL occur on the clock edge that samples the causing event; outputs reflect it one cycle after the event is presented.
REQ-030 start edge coincident with frame_tick SHALL be handled as the start edge only; frame counting begins after entering SERVE.

Reset
REQ-031 reset_n low SHALL asynchronously force state=IDLE, scores=0, winner=00, serve_dir=0, frame counter=0, start_q=0.
REQ-032 Reset outputs SHALL be ball_reset=1, ball_enable=0, paddle_enable=0.
REQ-033 Reset asserted mid-PLAY or mid-SERVE SHALL abort the match; after release the block waits in IDLE for a new start edge.

Verification
REQ-034 Reset, start pulse -> state 0->1 next edge; after 60 frame_ticks state=2, ball_enable=1, ball_reset=0.
REQ-035 In PLAY pulse miss_top -> score_1=1, serve_dir=1, state=3; after 30 ticks state=1.
REQ-036 miss_top and miss_bottom same cycle in PLAY -> scores unchanged, state=3, serve_dir unchanged.
REQ-037 Drive score_2 to 10 via miss_bottom -> state=4, winner=10, score_2=10; further miss pulses ignored; start edge -> state=1, scores 0, winner 00.
REQ-038 Hold start high across reset release -> stays IDLE; miss pulses in IDLE/SERVE ignored.
REQ-039 Assert reset_n low mid-PLAY with score_1=3 -> immediately state=0, score_1=0, ball_enable=0.
